neuron_unit_seq: RTL and testbench

Sequential, parametrised successor of the combinational neuron block. It holds one neuron's membrane potential across time steps and integrates a stream of axon events, one per cycle, using a per-axon weight-type selection. At end of step it applies leak, compares against thresholds, resets per the configured mode, and emits a spike result through a valid/ready handshake. It sits between the axon scheduler (event stream) and the spike router.

---
 rtl/neuron_pkg.sv | 30 +++
 rtl/neuron_sat_addsub.sv | 25 ++
 rtl/neuron_unit_seq.sv | 128 ++++++++++++
 tb/tb_neuron_unit_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the sequential neuron: FSM state encoding,
// reset-mode constants and the signed saturation clip.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INTEG = 2'd1,
        ST_FIRE  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    localparam logic RESET_ABS = 1'b0;
    localparam logic RESET_SUB = 1'b1;

    // Clamp a wide signed value into the w-bit two's complement range.
    function automatic logic signed [31:0] sat_clip(input logic signed [31:0] x,
                                                    input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/neuron_sat_addsub.sv
// Signed saturating add/subtract of a POT_W operand and a POT_W+1 operand;
// the extra headroom lets unsigned leak magnitudes pass through unharmed.
module neuron_sat_addsub
    import neuron_pkg::*;
#(
    parameter int POT_W = 8
) (
    input  logic signed [POT_W-1:0] a_i,
    input  logic signed [POT_W:0]   b_i,
    input  logic                    sub_i,
    output logic signed [POT_W-1:0] y_o
);

    logic signed [POT_W+1:0] a_x;
    logic signed [POT_W+1:0] b_x;
    logic signed [POT_W+1:0] r;

    always_comb begin
        a_x = (POT_W+2)'(a_i);
        b_x = (POT_W+2)'(b_i);
        r   = sub_i ? (a_x - b_x) : (a_x + b_x);
        y_o = POT_W'(sat_clip(32'(r), POT_W));
    end

endmodule

// File: rtl/neuron_unit_seq.sv
// Sequential neuron: integrates weighted axon events over a time step, then
// applies leak, threshold and reset, and hands the spike out via valid/ready.
module neuron_unit_seq
    import neuron_pkg::*;
#(
    parameter int POT_W       = 8,
    parameter int WEIGHT_W    = 8,
    parameter int NUM_WEIGHTS = 4,
    parameter int SEL_W       = $clog2(NUM_WEIGHTS)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enable_i,
    input  logic                            clear_i,
    input  logic                            start_i,
    input  logic [NUM_WEIGHTS*WEIGHT_W-1:0] weights_i,
    input  logic [POT_W-1:0]                leak_i,
    input  logic signed [POT_W-1:0]         pos_threshold_i,
    input  logic signed [POT_W-1:0]         neg_threshold_i,
    input  logic signed [POT_W-1:0]         pos_reset_i,
    input  logic signed [POT_W-1:0]         neg_reset_i,
    input  logic                            reset_mode_i,
    input  logic                            axon_valid_i,
    input  logic                            axon_spike_i,
    input  logic [SEL_W-1:0]                axon_sel_i,
    input  logic                            axon_last_i,
    output logic                            axon_ready_o,
    output logic                            spike_valid_o,
    output logic                            spike_o,
    input  logic                            spike_ready_i,
    output logic signed [POT_W-1:0]         potential_o,
    output logic                            busy_o
);

    state_e                  state_q, state_d;
    logic signed [POT_W-1:0] pot_q, pot_d;
    logic                    spike_q, spike_d;

    logic signed [WEIGHT_W-1:0] w_sel;
    logic signed [POT_W:0]      w_ext;
    logic signed [POT_W:0]      leak_ext;
    logic signed [POT_W:0]      pth_ext;
    logic signed [POT_W-1:0]    integ_sum;
    logic signed [POT_W-1:0]    leak_res;
    logic signed [POT_W-1:0]    sub_res;

    // Out-of-range selects fall back to weight type 0.
    always_comb begin
        w_sel = weights_i[WEIGHT_W-1:0];
        for (int k = 1; k < NUM_WEIGHTS; k++) begin
            if (axon_sel_i == SEL_W'(k))
                w_sel = weights_i[k*WEIGHT_W +: WEIGHT_W];
        end
        w_ext    = (POT_W+1)'(sat_clip(32'(w_sel), POT_W));
        leak_ext = $signed({1'b0, leak_i});
        pth_ext  = (POT_W+1)'(pos_threshold_i);
    end

    neuron_sat_addsub #(.POT_W(POT_W)) u_integ (
        .a_i(pot_q), .b_i(w_ext), .sub_i(1'b0), .y_o(integ_sum)
    );

    neuron_sat_addsub #(.POT_W(POT_W)) u_leak (
        .a_i(pot_q), .b_i(leak_ext), .sub_i(1'b1), .y_o(leak_res)
    );

    // Subtract-threshold reset operates on the already-leaked potential.
    neuron_sat_addsub #(.POT_W(POT_W)) u_thr (
        .a_i(leak_res), .b_i(pth_ext), .sub_i(1'b1), .y_o(sub_res)
    );

    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        spike_d = spike_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i)
                    pot_d = '0;
                if (start_i && enable_i)
                    state_d = ST_INTEG;
            end
            ST_INTEG: begin
                if (axon_valid_i) begin
                    if (axon_spike_i)
                        pot_d = integ_sum;
                    if (axon_last_i)
                        state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_d = ST_OUT;
                spike_d = 1'b0;
                pot_d   = leak_res;
                if (leak_res >= pos_threshold_i) begin
                    spike_d = 1'b1;
                    pot_d   = (reset_mode_i == RESET_SUB) ? sub_res : pos_reset_i;
                end else if (leak_res <= neg_threshold_i) begin
                    pot_d = neg_reset_i;
                end
            end
            ST_OUT: begin
                if (spike_ready_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pot_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pot_q   <= pot_d;
            spike_q <= spike_d;
        end
    end

    assign axon_ready_o  = (state_q == ST_INTEG);
    assign spike_valid_o = (state_q == ST_OUT);
    assign busy_o        = (state_q != ST_IDLE);
    assign spike_o       = spike_q;
    assign potential_o   = pot_q;

endmodule

// File: tb/tb_neuron_unit_seq.sv
// Self-checking bench for neuron_unit_seq: directed scenarios plus randomized
// steps compared against an integer reference model of the neuron.
module tb_neuron_unit_seq;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              enable_i = 1'b1;
    logic              clear_i = 1'b0;
    logic              start_i = 1'b0;
    logic [31:0]       weights_i;
    logic [7:0]        leak_i;
    logic signed [7:0] pos_threshold_i, neg_threshold_i, pos_reset_i, neg_reset_i;
    logic              reset_mode_i;
    logic              axon_valid_i = 1'b0;
    logic              axon_spike_i = 1'b0;
    logic [1:0]        axon_sel_i = 2'd0;
    logic              axon_last_i = 1'b0;
    logic              axon_ready_o, spike_valid_o, spike_o, busy_o;
    logic              spike_ready_i = 1'b0;
    logic signed [7:0] potential_o;

    int cfg_w[4];
    int cfg_leak, cfg_pth, cfg_nth, cfg_prst, cfg_nrst, cfg_mode;
    int b_spk[16], b_sel[16], b_gap[16];
    int ref_v, ref_spike;
    int n_checks = 0, n_pass = 0;

    assign weights_i       = {8'(cfg_w[3]), 8'(cfg_w[2]), 8'(cfg_w[1]), 8'(cfg_w[0])};
    assign leak_i          = 8'(cfg_leak);
    assign pos_threshold_i = 8'(cfg_pth);
    assign neg_threshold_i = 8'(cfg_nth);
    assign pos_reset_i     = 8'(cfg_prst);
    assign neg_reset_i     = 8'(cfg_nrst);
    assign reset_mode_i    = cfg_mode[0];

    neuron_unit_seq #(.POT_W(8), .WEIGHT_W(8), .NUM_WEIGHTS(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
        .start_i(start_i), .weights_i(weights_i), .leak_i(leak_i),
        .pos_threshold_i(pos_threshold_i), .neg_threshold_i(neg_threshold_i),
        .pos_reset_i(pos_reset_i), .neg_reset_i(neg_reset_i),
        .reset_mode_i(reset_mode_i), .axon_valid_i(axon_valid_i),
        .axon_spike_i(axon_spike_i), .axon_sel_i(axon_sel_i),
        .axon_last_i(axon_last_i), .axon_ready_o(axon_ready_o),
        .spike_valid_o(spike_valid_o), .spike_o(spike_o),
        .spike_ready_i(spike_ready_i), .potential_o(potential_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic int sat8(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    // Reference: whole step computed with plain integer arithmetic.
    task automatic model_step(input int n, input bit clr);
        int v;
        if (clr) ref_v = 0;
        for (int i = 0; i < n; i++)
            if (b_spk[i] != 0) ref_v = sat8(ref_v + cfg_w[(b_sel[i] < 4) ? b_sel[i] : 0]);
        v = sat8(ref_v - cfg_leak);
        ref_spike = 0;
        if (v >= cfg_pth) begin
            ref_spike = 1;
            v = (cfg_mode != 0) ? sat8(v - cfg_pth) : cfg_prst;
        end else if (v <= cfg_nth) begin
            v = cfg_nrst;
        end
        ref_v = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full step up to the OUT state; lat counts cycles from the
    // edge accepting the last beat until spike_valid_o is seen (bounded).
    task automatic run_step(input int n, input bit clr, output int lat);
        clear_i = clr;
        start_i = 1'b1;
        tick();
        clear_i = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < b_gap[i]; g++) begin
                axon_valid_i = 1'b0;
                tick();
            end
            axon_valid_i = 1'b1;
            axon_spike_i = b_spk[i][0];
            axon_sel_i   = 2'(b_sel[i]);
            axon_last_i  = (i == n - 1);
            tick();
        end
        axon_valid_i = 1'b0;
        axon_last_i  = 1'b0;
        axon_spike_i = 1'b0;
        lat = 1;
        while (!spike_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        model_step(n, clr);
    endtask

    task automatic release_out();
        spike_ready_i = 1'b1;
        tick();
        spike_ready_i = 1'b0;
    endtask

    task automatic set_beat(input int i, input int spk, input int sel, input int gap);
        b_spk[i] = spk;
        b_sel[i] = sel;
        b_gap[i] = gap;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        n_checks++;
        if ({potential_o, spike_o, spike_valid_o, axon_ready_o, busy_o} !== 12'h000)
            $display("FAIL reset_outputs: got pot=%0d sp=%b sv=%b ar=%b busy=%b required all 0",
                     potential_o, spike_o, spike_valid_o, axon_ready_o, busy_o);
        else n_pass++;
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        ref_v = 0;
    endtask

    task automatic test_integrate_basic();
        int lat;
        cfg_w = '{10, 20, -5, 0};
        cfg_leak = 2; cfg_pth = 50; cfg_nth = -128; cfg_prst = 0; cfg_nrst = 0; cfg_mode = 0;
        set_beat(0, 1, 1, 0); set_beat(1, 1, 1, 0); set_beat(2, 1, 0, 0);
        run_step(3, 1'b0, lat);
        n_checks++;
        if (lat !== 2) $display("FAIL basic_latency: got %0d required 2", lat); else n_pass++;
        n_checks++;
        if (potential_o !== 8'sd48) $display("FAIL basic_pot: got %0d required 48", potential_o); else n_pass++;
        n_checks++;
        if (spike_o !== 1'b0) $display("FAIL basic_spike: got %b required 0", spike_o); else n_pass++;
        n_checks++;
        if (potential_o !== 8'(ref_v)) $display("FAIL basic_model: got %0d required %0d", potential_o, ref_v); else n_pass++;
        release_out();
    endtask

    task automatic test_fire_modes();
        int lat;
        set_beat(0, 1, 0, 0);
        run_step(1, 1'b0, lat);
        n_checks++;
        if (spike_o !== 1'b1 || potential_o !== 8'sd0)
            $display("FAIL fire_abs: got spike=%b pot=%0d required spike=1 pot=0", spike_o, potential_o);
        else n_pass++;
        release_out();
        set_beat(0, 1, 1, 0); set_beat(1, 1, 1, 0); set_beat(2, 1, 0, 0);
        run_step(3, 1'b0, lat);
        release_out();
        cfg_mode = 1;
        set_beat(0, 1, 0, 0);
        run_step(1, 1'b0, lat);
        n_checks++;
        if (spike_o !== 1'b1 || potential_o !== 8'sd6)
            $display("FAIL fire_sub: got spike=%b pot=%0d required spike=1 pot=6", spike_o, potential_o);
        else n_pass++;
        release_out();
        cfg_mode = 0;
    endtask

    task automatic test_saturation();
        int lat;
        cfg_w = '{100, 20, 0, 0};
        cfg_leak = 0; cfg_pth = 127; cfg_nth = -100; cfg_nrst = -20;
        set_beat(0, 1, 0, 0); set_beat(1, 1, 1, 0);
        run_step(2, 1'b1, lat);
        n_checks++;
        if (potential_o !== 8'sd120) $display("FAIL sat_build: got %0d required 120", potential_o); else n_pass++;
        release_out();
        cfg_leak = 1;
        set_beat(0, 1, 0, 0); set_beat(1, 1, 0, 1);
        run_step(2, 1'b0, lat);
        n_checks++;
        if (potential_o !== 8'sd126 || spike_o !== 1'b0)
            $display("FAIL sat_pos: got pot=%0d spike=%b required pot=126 spike=0", potential_o, spike_o);
        else n_pass++;
        release_out();
        cfg_w = '{-50, -40, 0, 0};
        cfg_leak = 0;
        set_beat(0, 1, 0, 0); set_beat(1, 1, 1, 0);
        run_step(2, 1'b1, lat);
        n_checks++;
        if (potential_o !== -8'sd90) $display("FAIL sat_negbuild: got %0d required -90", potential_o); else n_pass++;
        release_out();
        set_beat(0, 1, 0, 0); set_beat(1, 1, 0, 0);
        run_step(2, 1'b0, lat);
        n_checks++;
        if (potential_o !== -8'sd20) $display("FAIL sat_negreset: got %0d required -20", potential_o); else n_pass++;
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        cfg_w = '{60, 0, 0, 0};
        cfg_leak = 0; cfg_pth = 50; cfg_nth = -128; cfg_prst = 3; cfg_mode = 0;
        set_beat(0, 1, 0, 0);
        run_step(1, 1'b1, lat);
        for (int c = 0; c < 5; c++) begin
            start_i = (c == 2);
            n_checks++;
            if (spike_valid_o !== 1'b1 || spike_o !== 1'b1 || busy_o !== 1'b1 || potential_o !== 8'sd3)
                $display("FAIL hold_cycle%0d: got sv=%b sp=%b busy=%b pot=%0d required 1/1/1/3",
                         c, spike_valid_o, spike_o, busy_o, potential_o);
            else n_pass++;
            tick();
        end
        start_i = 1'b0;
        release_out();
        n_checks++;
        if (spike_valid_o !== 1'b0 || busy_o !== 1'b0 || axon_ready_o !== 1'b0)
            $display("FAIL hold_release: got sv=%b busy=%b ar=%b required 0/0/0",
                     spike_valid_o, busy_o, axon_ready_o);
        else n_pass++;
        ref_v = 3;
    endtask

    task automatic test_reset_mid();
        int lat;
        cfg_w = '{30, 0, 0, 0};
        cfg_leak = 1; cfg_pth = 127; cfg_nth = -128;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axon_valid_i = 1'b1; axon_spike_i = 1'b1; axon_sel_i = 2'd0;
            tick();
        end
        axon_valid_i = 1'b0; axon_spike_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({potential_o, spike_o, spike_valid_o, axon_ready_o, busy_o} !== 12'h000)
            $display("FAIL midreset_outputs: got pot=%0d ar=%b busy=%b required all 0",
                     potential_o, axon_ready_o, busy_o);
        else n_pass++;
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        ref_v = 0;
        set_beat(0, 1, 0, 0);
        run_step(1, 1'b0, lat);
        n_checks++;
        if (potential_o !== 8'sd29) $display("FAIL midreset_restart: got %0d required 29", potential_o); else n_pass++;
        release_out();
    endtask

    task automatic test_leak_only();
        int lat;
        cfg_w = '{40, 9, -3, 0};
        cfg_leak = 0; cfg_pth = 127;
        set_beat(0, 1, 0, 0);
        run_step(1, 1'b1, lat);
        release_out();
        cfg_leak = 3;
        set_beat(0, 0, 0, 1); set_beat(1, 0, 2, 2); set_beat(2, 1, 3, 0); set_beat(3, 0, 1, 1);
        run_step(4, 1'b0, lat);
        n_checks++;
        if (potential_o !== 8'sd37 || lat !== 2)
            $display("FAIL leak_only: got pot=%0d lat=%0d required pot=37 lat=2", potential_o, lat);
        else n_pass++;
        release_out();
    endtask

    task automatic test_enable_clear();
        enable_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || axon_ready_o !== 1'b0)
            $display("FAIL enable_ignore: got busy=%b ar=%b required 0/0", busy_o, axon_ready_o);
        else n_pass++;
        enable_i = 1'b1;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_checks++;
        if (potential_o !== 8'sd0) $display("FAIL idle_clear: got %0d required 0", potential_o); else n_pass++;
        ref_v = 0;
    endtask

    task automatic test_random();
        int lat, n, hold;
        bit clr;
        for (int s = 0; s < 30; s++) begin
            for (int k = 0; k < 4; k++) cfg_w[k] = int'($urandom_range(0, 255)) - 128;
            cfg_leak = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            cfg_pth  = int'($urandom_range(0, 127));
            cfg_nth  = -int'($urandom_range(0, 128));
            cfg_prst = int'($urandom_range(0, 255)) - 128;
            cfg_nrst = int'($urandom_range(0, 255)) - 128;
            cfg_mode = int'($urandom_range(0, 1));
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++)
                set_beat(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            clr = ($urandom_range(0, 3) == 0);
            run_step(n, clr, lat);
            n_checks++;
            if (lat !== 2 || potential_o !== 8'(ref_v) || spike_o !== ref_spike[0])
                $display("FAIL rand_step%0d: got lat=%0d pot=%0d spike=%b required lat=2 pot=%0d spike=%0d",
                         s, lat, potential_o, spike_o, ref_v, ref_spike);
            else n_pass++;
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) tick();
            release_out();
        end
    endtask

    initial begin
        cfg_w = '{0, 0, 0, 0};
        cfg_leak = 0; cfg_pth = 0; cfg_nth = -128; cfg_prst = 0; cfg_nrst = 0; cfg_mode = 0;
        test_reset();
        test_integrate_basic();
        test_fire_modes();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_leak_only();
        test_enable_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
